// File: rtl/uart_fifo_bridge.sv
// Byte-stream bridge between the fabric and the uart send/done, ready/dout handshakes.
// TX FIFO feeds a three-state sender; RX FIFO is read through a show-ahead port.
module uart_fifo_bridge #(
  parameter int AddrWidth   = 4,
  parameter int ErrCntWidth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  output logic                   tx_full,
  output logic [AddrWidth:0]     tx_level,
  output logic                   tx_busy,
  output logic                   tx_drop,
  output logic [7:0]             uart_din,
  output logic                   uart_send,
  input  logic                   uart_done,
  input  logic                   uart_ready,
  input  logic [7:0]             uart_dout,
  input  logic                   uart_rxerr,
  output logic [7:0]             rd_data,
  output logic                   rd_empty,
  input  logic                   rd_en,
  output logic [AddrWidth:0]     rx_level,
  output logic                   rx_ovf,
  output logic [ErrCntWidth-1:0] rx_err_cnt,
  input  logic                   flag_clr
);

  localparam int Depth = 1 << AddrWidth;
  localparam logic [AddrWidth:0] FullLvl =
    (AddrWidth+1)'(Depth);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  // uart shifts din[0] first, so byte bit 7 sits at din[0]
  function automatic logic [7:0] rev8(
    input logic [7:0] b
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [7:0]           tx_mem [Depth];
  logic [AddrWidth-1:0] tx_wptr;
  logic [AddrWidth-1:0] tx_rptr;
  logic [AddrWidth:0]   tx_cnt;
  logic                 tx_empty;
  logic                 tx_push;
  logic                 tx_pop;

  tx_state_e state;
  tx_state_e state_nxt;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FullLvl);
  assign tx_level = tx_cnt;
  // a pop in the same cycle frees the slot
  assign tx_push  = wr_en && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
    end else begin
      if (tx_push) begin
        tx_wptr <= tx_wptr + AddrWidth'(1);
      end
      if (tx_pop) begin
        tx_rptr <= tx_rptr + AddrWidth'(1);
      end
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (AddrWidth+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (AddrWidth+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop <= 1'b0;
    end else if (flag_clr) begin
      tx_drop <= 1'b0;
    end else if (wr_en && !tx_push) begin
      tx_drop <= 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!tx_empty) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (uart_done) begin
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_send = 1'b0;
    tx_busy   = 1'b0;
    tx_pop    = 1'b0;
    unique case (state)
      IDLE: tx_pop = !tx_empty;
      SEND: begin
        uart_send = 1'b1;
        tx_busy   = 1'b1;
      end
      GAP:     tx_busy = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_din <= 8'h00;
    end else if (tx_pop) begin
      uart_din <= rev8(tx_mem[tx_rptr]);
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]           rx_mem [Depth];
  logic [AddrWidth-1:0] rx_wptr;
  logic [AddrWidth-1:0] rx_rptr;
  logic [AddrWidth:0]   rx_cnt;
  logic                 rx_full;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_acc;

  assign rd_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FullLvl);
  assign rx_level = rx_cnt;
  assign rx_push  = uart_ready && !uart_rxerr;
  assign rx_pop   = rd_en && !rd_empty;
  assign rx_acc   = rx_push && (!rx_full || rx_pop);
  assign rd_data  = rd_empty ? 8'h00 : rx_mem[rx_rptr];

  always_ff @(posedge clk) begin
    if (rx_acc) begin
      rx_mem[rx_wptr] <= rev8(uart_dout);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (rx_acc) begin
        rx_wptr <= rx_wptr + AddrWidth'(1);
      end
      if (rx_pop) begin
        rx_rptr <= rx_rptr + AddrWidth'(1);
      end
      unique case ({rx_acc, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (AddrWidth+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (AddrWidth+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf <= 1'b0;
    end else if (flag_clr) begin
      rx_ovf <= 1'b0;
    end else if (rx_push && !rx_acc) begin
      rx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_err_cnt <= '0;
    end else if (flag_clr) begin
      rx_err_cnt <= '0;
    end else if (uart_rxerr && (rx_err_cnt != '1)) begin
      rx_err_cnt <= rx_err_cnt + ErrCntWidth'(1);
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: directed TX/RX traffic,
// expected bytes queued at issue time and checked by a negedge monitor.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       tx_full;
  logic [4:0] tx_level;
  logic       tx_busy;
  logic       tx_drop;
  logic [7:0] uart_din;
  logic       uart_send;
  logic       uart_done = 1'b0;
  logic       uart_ready = 1'b0;
  logic [7:0] uart_dout = 8'h00;
  logic       uart_rxerr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       rd_en = 1'b0;
  logic [4:0] rx_level;
  logic       rx_ovf;
  logic [7:0] rx_err_cnt;
  logic       flag_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic send_q = 1'b0;

  uart_fifo_bridge #(.AddrWidth(4), .ErrCntWidth(8)) dut (
    .clk(clk), .reset(reset),
    .wr_data(wr_data), .wr_en(wr_en),
    .tx_full(tx_full), .tx_level(tx_level),
    .tx_busy(tx_busy), .tx_drop(tx_drop),
    .uart_din(uart_din), .uart_send(uart_send),
    .uart_done(uart_done), .uart_ready(uart_ready),
    .uart_dout(uart_dout), .uart_rxerr(uart_rxerr),
    .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_en(rd_en), .rx_level(rx_level),
    .rx_ovf(rx_ovf), .rx_err_cnt(rx_err_cnt),
    .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send();
    int n = 0;
    while (!uart_send && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!uart_send) begin
      failures++;
      $display("FAIL send_timeout got=0 exp=1 t=%0t", $time);
    end
  endtask

  task automatic pulse_done();
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_ready = 1'b1;
    uart_dout  = rev8(b);
    rx_exp.push_back(b);
    tick();
    uart_ready = 1'b0;
  endtask

  task automatic drain_rx();
    int n = 0;
    rd_en = 1'b1;
    while (!rd_empty && n < 40) begin
      tick();
      n++;
    end
    rd_en = 1'b0;
    check("rx_drained", {31'd0, rd_empty}, 32'd1);
  endtask

  // Monitor: compares each new frame and each RX pop with the scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      send_q = 1'b0;
    end else begin
      if (uart_send && !send_q) begin
        if (tx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected got=%0h exp=none", uart_din);
        end else begin
          e = tx_exp.pop_front();
          check("tx_din", {24'd0, uart_din}, {24'd0, rev8(e)});
        end
      end
      send_q = uart_send;
      if (rd_en && !rd_empty) begin
        if (rx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected got=%0h exp=none", rd_data);
        end else begin
          e = rx_exp.pop_front();
          check("rx_data", {24'd0, rd_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_send", {31'd0, uart_send}, 0);
    check("rst_din", {24'd0, uart_din}, 0);
    check("rst_busy", {31'd0, tx_busy}, 0);
    check("rst_full", {31'd0, tx_full}, 0);
    check("rst_empty", {31'd0, rd_empty}, 1);
    check("rst_rdata", {24'd0, rd_data}, 0);
    check("rst_levels", {22'd0, tx_level, rx_level}, 0);
    check("rst_flags", {22'd0, tx_drop, rx_ovf, rx_err_cnt}, 0);

    // 1: single byte, 2-cycle latency
    wr_data = 8'hA5;
    wr_en = 1'b1;
    tx_exp.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("t1_send_c1", {31'd0, uart_send}, 0);
    tick();
    check("t1_send_c2", {31'd0, uart_send}, 1);
    check("t1_din", {24'd0, uart_din}, 32'hA5);
    check("t1_level", {27'd0, tx_level}, 0);
    pulse_done();
    check("t1_gap_send", {31'd0, uart_send}, 0);
    check("t1_gap_busy", {31'd0, tx_busy}, 1);
    tick();
    check("t1_idle_busy", {31'd0, tx_busy}, 0);
    check("t1_idle_send", {31'd0, uart_send}, 0);

    // 2: fill TX with the sender stalled
    for (int i = 1; i <= 17; i++) begin
      wr_data = 8'(i);
      wr_en = 1'b1;
      tx_exp.push_back(8'(i));
      tick();
    end
    check("t2_level", {27'd0, tx_level}, 16);
    check("t2_full", {31'd0, tx_full}, 1);
    check("t2_drop0", {31'd0, tx_drop}, 0);
    wr_data = 8'h12;
    tick();
    wr_en = 1'b0;
    check("t2_drop1", {31'd0, tx_drop}, 1);
    check("t2_level_kept", {27'd0, tx_level}, 16);
    for (int i = 0; i < 17; i++) begin
      wait_send();
      pulse_done();
    end
    repeat (5) tick();
    check("t2_level_end", {27'd0, tx_level}, 0);
    check("t2_send_end", {31'd0, uart_send}, 0);

    // 3: fill RX, overflow, then full + read
    for (int i = 0; i < 16; i++) rx_byte(8'(i));
    check("t3_level", {27'd0, rx_level}, 16);
    check("t3_ovf0", {31'd0, rx_ovf}, 0);
    check("t3_head", {24'd0, rd_data}, 0);
    uart_ready = 1'b1;
    uart_dout = rev8(8'h40);
    tick();
    uart_ready = 1'b0;
    check("t3_ovf1", {31'd0, rx_ovf}, 1);
    check("t3_level_ovf", {27'd0, rx_level}, 16);
    rd_en = 1'b1;
    rx_byte(8'h41);
    rd_en = 1'b0;
    check("t3_level_rw", {27'd0, rx_level}, 16);
    check("t3_head2", {24'd0, rd_data}, 1);

    // 4: frame errors
    uart_ready = 1'b1;
    uart_rxerr = 1'b1;
    uart_dout = 8'h55;
    tick();
    uart_ready = 1'b0;
    uart_rxerr = 1'b0;
    check("t4_level", {27'd0, rx_level}, 16);
    check("t4_cnt1", {24'd0, rx_err_cnt}, 1);
    uart_rxerr = 1'b1;
    repeat (300) tick();
    uart_rxerr = 1'b0;
    check("t4_cnt_sat", {24'd0, rx_err_cnt}, 255);
    flag_clr = 1'b1;
    uart_rxerr = 1'b1;
    tick();
    flag_clr = 1'b0;
    uart_rxerr = 1'b0;
    check("t4_clr_cnt", {24'd0, rx_err_cnt}, 0);
    check("t4_clr_ovf", {31'd0, rx_ovf}, 0);
    check("t4_clr_drop", {31'd0, tx_drop}, 0);
    drain_rx();
    check("t4_rx_sb", rx_exp.size(), 0);

    // 6: show-ahead drain
    rx_byte(8'h10);
    rx_byte(8'h20);
    rx_byte(8'h30);
    check("t6_head", {24'd0, rd_data}, 32'h10);
    check("t6_level", {27'd0, rx_level}, 3);
    rd_en = 1'b1;
    repeat (5) tick();
    rd_en = 1'b0;
    check("t6_empty", {31'd0, rd_empty}, 1);
    check("t6_level0", {27'd0, rx_level}, 0);
    check("t6_rdata0", {24'd0, rd_data}, 0);

    // 5: reset in the middle of a frame
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'h61 + i);
      wr_en = 1'b1;
      tx_exp.push_back(8'(8'h61 + i));
      tick();
    end
    wr_en = 1'b0;
    wait_send();
    check("t5_level", {27'd0, tx_level}, 3);
    rx_byte(8'h77);
    reset = 1'b1;
    tx_exp.delete();
    rx_exp.delete();
    tick();
    check("t5_send", {31'd0, uart_send}, 0);
    check("t5_level0", {27'd0, tx_level}, 0);
    check("t5_empty", {31'd0, rd_empty}, 1);
    check("t5_busy", {31'd0, tx_busy}, 0);
    reset = 1'b0;
    repeat (8) tick();
    check("t5_no_send", {31'd0, uart_send}, 0);
    check("t5_busy_end", {31'd0, tx_busy}, 0);

    check("tx_sb_empty", tx_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
